// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types for the fetch slice: FSM states, decoded-field bundle,
// branch-prediction and RVFI sideband structs.
package rv32i_types;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_BR    = 7'b1100011;

  typedef enum logic [1:0] {
    RESET_ST = 2'd0,
    FETCH    = 2'd1,
    DRAIN    = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        pred_taken;
    logic [31:0] pred_target;
  } br_pred_sigs;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [1:0]  ixl;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_sigs;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
    br_pred_sigs pred;
  } decode_t;

endpackage

// File: rtl/if_fetch_inst_decode.sv
// Combinational RV32I field/immediate splitter; static branch prediction is
// added when BR_PRED_EN is defined.
module inst_decode
  import rv32i_types::*;
(
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output decode_t     dec_o
);

  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] u_imm;
  logic [31:0] j_imm;
  logic [31:0] seq_pc;

  assign i_imm  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign s_imm  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign b_imm  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign u_imm  = {inst_i[31:12], 12'b0};
  assign j_imm  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign seq_pc = pc_i + 32'd4;

  always_comb begin
    dec_o                  = '0;
    dec_o.opcode           = inst_i[6:0];
    dec_o.funct3           = inst_i[14:12];
    dec_o.funct7           = inst_i[31:25];
    dec_o.rs1              = inst_i[19:15];
    dec_o.rs2              = inst_i[24:20];
    dec_o.rd               = inst_i[11:7];
    dec_o.i_imm            = i_imm;
    dec_o.s_imm            = s_imm;
    dec_o.b_imm            = b_imm;
    dec_o.u_imm            = u_imm;
    dec_o.j_imm            = j_imm;
    dec_o.pred.pred_taken  = 1'b0;
    dec_o.pred.pred_target = seq_pc;
`ifdef BR_PRED_EN
    // Backward conditional branches are assumed to be loop closers.
    if (inst_i[6:0] == OP_JAL) begin
      dec_o.pred.pred_taken  = 1'b1;
      dec_o.pred.pred_target = pc_i + j_imm;
    end else if (inst_i[6:0] == OP_BR && inst_i[31]) begin
      dec_o.pred.pred_taken  = 1'b1;
      dec_o.pred.pred_target = pc_i + b_imm;
    end
`else
`endif
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage with IF/ID output register, stall/redirect handling
// and optional static prediction (BR_PRED_EN).
module if_fetch
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] i_imm_o,
  output logic [31:0] s_imm_o,
  output logic [31:0] b_imm_o,
  output logic [31:0] u_imm_o,
  output logic [31:0] j_imm_o,
  output br_pred_sigs br_pred_sigs_o,
  output rvfi_sigs    rvfi_sigs_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  decode_t      dec_q, dec_d;
  decode_t      dec_w;

  inst_decode u_inst_decode (
    .inst_i (imem_rdata),
    .pc_i   (fetch_pc_q),
    .dec_o  (dec_w)
  );

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    valid_d      = valid_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    dec_d        = dec_q;
    case (state_q)
      RESET_ST: begin
        state_d = FETCH;
        valid_d = 1'b0;
        if (redirect_i) fetch_pc_d = redirect_pc_i;
      end
      FETCH: begin
        if (redirect_i) begin
          valid_d    = 1'b0;
          fetch_pc_d = redirect_pc_i;
          // Outstanding request must complete at its original address first.
          if (!imem_resp) begin
            state_d      = DRAIN;
            drain_addr_d = fetch_pc_q;
          end
        end else if (stall_i && valid_q) begin
          valid_d = 1'b1;
        end else if (imem_resp) begin
          valid_d    = 1'b1;
          pc_d       = fetch_pc_q;
          inst_d     = imem_rdata;
          dec_d      = dec_w;
          fetch_pc_d = dec_w.pred.pred_target;
        end else begin
          valid_d = 1'b0;
        end
      end
      DRAIN: begin
        valid_d = 1'b0;
        if (redirect_i) fetch_pc_d = redirect_pc_i;
        if (imem_resp)  state_d    = FETCH;
      end
      default: state_d = RESET_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RESET_ST;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= '0;
      valid_q      <= 1'b0;
      pc_q         <= '0;
      inst_q       <= '0;
      dec_q        <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      dec_q        <= dec_d;
    end
  end

  assign imem_read      = (state_q != RESET_ST);
  assign imem_address   = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
  assign valid_o        = valid_q;
  assign pc_o           = pc_q;
  assign opcode_o       = dec_q.opcode;
  assign funct3_o       = dec_q.funct3;
  assign funct7_o       = dec_q.funct7;
  assign rs1_o          = dec_q.rs1;
  assign rs2_o          = dec_q.rs2;
  assign rd_o           = dec_q.rd;
  assign i_imm_o        = dec_q.i_imm;
  assign s_imm_o        = dec_q.s_imm;
  assign b_imm_o        = dec_q.b_imm;
  assign u_imm_o        = dec_q.u_imm;
  assign j_imm_o        = dec_q.j_imm;
  assign br_pred_sigs_o = dec_q.pred;

  always_comb begin
    rvfi_sigs_o          = '0;
    rvfi_sigs_o.inst     = inst_q;
    rvfi_sigs_o.pc_rdata = pc_q;
    rvfi_sigs_o.pc_wdata = dec_q.pred.pred_target;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: random memory/stall/redirect traffic checked
// against a program-order reference model (honours BR_PRED_EN).
`timescale 1ns/1ps
module tb_if_fetch;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst, imem_read, imem_resp, stall_i, redirect_i, valid_o;
  logic [31:0] imem_address, imem_rdata, redirect_pc_i, pc_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] i_imm_o, s_imm_o, b_imm_o, u_imm_o, j_imm_o;
  br_pred_sigs br_pred_sigs_o;
  rvfi_sigs    rvfi_sigs_o;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .pc_o(pc_o),
    .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .i_imm_o(i_imm_o), .s_imm_o(s_imm_o), .b_imm_o(b_imm_o),
    .u_imm_o(u_imm_o), .j_imm_o(j_imm_o),
    .br_pred_sigs_o(br_pred_sigs_o), .rvfi_sigs_o(rvfi_sigs_o)
  );

  int checks = 0;
  int passes = 0;
  int delivered = 0;
  logic [31:0] mem [256];

  typedef struct {
    logic [31:0]  pc;
    logic [31:0]  inst;
    logic [31:0]  next;
    logic [224:0] fields;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic ok, input string detail);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Reference: decode by arithmetic on the signed word, then apply prediction rules.
  function automatic exp_t make_exp(input logic [31:0] pc);
    exp_t        e;
    logic [31:0] w, i_imm, s_imm, b_imm, u_imm, j_imm, tgt;
    logic        taken;
    int          sw;
    w     = mem[pc[9:2]];
    sw    = $signed(w);
    i_imm = 32'(sw >>> 20);
    s_imm = (32'(sw >>> 25) << 5) | 32'(w[11:7]);
    b_imm = (32'(sw >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    u_imm = w & 32'hFFFF_F000;
    j_imm = (32'(sw >>> 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    taken = 1'b0;
    tgt   = pc + 32'd4;
`ifdef BR_PRED_EN
    if (w[6:0] == 7'b1101111) begin
      taken = 1'b1;
      tgt   = pc + j_imm;
    end else if (w[6:0] == 7'b1100011 && sw < 0) begin
      taken = 1'b1;
      tgt   = pc + b_imm;
    end
`endif
    e.pc     = pc;
    e.inst   = w;
    e.next   = tgt;
    e.fields = {w[6:0], w[14:12], w[31:25], w[19:15], w[24:20], w[11:7],
                i_imm, s_imm, b_imm, u_imm, j_imm, taken, tgt};
    return e;
  endfunction

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic resp_en);
    @(posedge clk);
    #1;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_resp     = resp_en && imem_read;
    imem_rdata    = imem_resp ? mem[imem_address[9:2]] : $urandom;
  endtask

  // Monitor: pops one expected instruction per consumed output.
  initial begin
    exp_t        e;
    rvfi_sigs    rv_exp;
    logic [224:0] act;
    logic        prev_ok = 1'b0, prev_read = 1'b0, prev_resp = 1'b0;
    logic        prev_valid = 1'b0, prev_stall = 1'b0, prev_redir = 1'b0;
    logic [31:0] prev_addr = '0, prev_pc = '0, prev_inst = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        exp_q.delete();
        exp_q.push_back(make_exp(RESET_PC));
        prev_ok = 1'b0;
      end else begin
        if (prev_ok && prev_read && !prev_resp)
          check("addr_stable", imem_read && imem_address == prev_addr,
                $sformatf("read=%0b addr=%h required read=1 addr=%h", imem_read, imem_address, prev_addr));
        if (prev_ok && prev_valid && prev_stall && !prev_redir)
          check("stall_hold", valid_o && pc_o == prev_pc && rvfi_sigs_o.inst == prev_inst,
                $sformatf("valid=%0b pc=%h inst=%h required valid=1 pc=%h inst=%h",
                          valid_o, pc_o, rvfi_sigs_o.inst, prev_pc, prev_inst));
        if (valid_o && !stall_i && exp_q.size() > 0) begin
          e   = exp_q.pop_front();
          act = {opcode_o, funct3_o, funct7_o, rs1_o, rs2_o, rd_o,
                 i_imm_o, s_imm_o, b_imm_o, u_imm_o, j_imm_o,
                 br_pred_sigs_o.pred_taken, br_pred_sigs_o.pred_target};
          check("sb_pc", pc_o == e.pc, $sformatf("pc=%h required %h", pc_o, e.pc));
          check("sb_fields", act == e.fields,
                $sformatf("pc=%h fields=%h required %h", e.pc, act, e.fields));
          rv_exp          = '0;
          rv_exp.inst     = e.inst;
          rv_exp.pc_rdata = e.pc;
          rv_exp.pc_wdata = e.next;
          check("sb_rvfi", rvfi_sigs_o == rv_exp,
                $sformatf("pc=%h rvfi=%h required %h", e.pc, rvfi_sigs_o, rv_exp));
          delivered++;
          exp_q.push_back(make_exp(e.next));
        end
        if (redirect_i) begin
          exp_q.delete();
          exp_q.push_back(make_exp(redirect_pc_i));
        end
        prev_ok    = 1'b1;
        prev_read  = imem_read;
        prev_resp  = imem_resp;
        prev_addr  = imem_address;
        prev_valid = valid_o;
        prev_stall = stall_i;
        prev_redir = redirect_i;
        prev_pc    = pc_o;
        prev_inst  = rvfi_sigs_o.inst;
      end
    end
  end

  initial begin
    logic [31:0] w, exp_pc;
    logic        got;
    logic [31:0] b2b_pcs [6];
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_resp = 1'b0; imem_rdata = '0;

    // Random program: JAL/BR with word-aligned offsets mixed with arbitrary words.
    for (int k = 0; k < 256; k++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: begin w[6:0] = 7'b1101111; w[21] = 1'b0; end
        1: begin w[6:0] = 7'b1100011; w[8]  = 1'b0; end
        default: ;
      endcase
      mem[k] = w;
    end
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_8113;
    mem[3] = 32'h0031_0193;
    mem[4] = 32'hFE00_0CE3;  // beq x0,x0,-8 at 4000_0010

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state",
          ({valid_o, imem_read, pc_o, opcode_o, funct3_o, funct7_o, rs1_o, rs2_o, rd_o,
            i_imm_o, s_imm_o, b_imm_o, u_imm_o, j_imm_o} == '0) &&
          (br_pred_sigs_o == '0) && (rvfi_sigs_o == '0),
          $sformatf("valid=%0b read=%0b pc=%h pred=%h required all zero",
                    valid_o, imem_read, pc_o, br_pred_sigs_o));

    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("reset_st_idle", !imem_read, $sformatf("read=%0b required 0", imem_read));
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      got = imem_read;
    end
    check("first_req", got && imem_address == RESET_PC,
          $sformatf("read=%0b addr=%h required read=1 addr=%h", got, imem_address, RESET_PC));

    // First fetch with 1-cycle memory, then back-to-back words.
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    b2b_pcs[0] = 32'h4000_0000; b2b_pcs[1] = 32'h4000_0004; b2b_pcs[2] = 32'h4000_0008;
    b2b_pcs[3] = 32'h4000_000C; b2b_pcs[4] = 32'h4000_0010;
`ifdef BR_PRED_EN
    b2b_pcs[5] = 32'h4000_0008;
`else
    b2b_pcs[5] = 32'h4000_0014;
`endif
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      exp_pc = b2b_pcs[i];
      check("b2b", valid_o && pc_o == exp_pc,
            $sformatf("step %0d valid=%0b pc=%h required valid=1 pc=%h", i, valid_o, pc_o, exp_pc));
      if (i == 0)
        check("first_fields", i_imm_o == 32'd0 && rd_o == 5'd0,
              $sformatf("i_imm=%h rd=%0d required 0/0", i_imm_o, rd_o));
    end

    // Stall for 3 cycles with the memory still answering.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, '0, ($urandom_range(0, 1) == 1));
      @(negedge clk);
      check("stall_req", imem_read && valid_o,
            $sformatf("read=%0b valid=%0b required 1/1", imem_read, valid_o));
    end

    // Redirect with an outstanding request; stale response two cycles later.
    drive(1'b0, 1'b1, 32'h4000_0100, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("drain_invalid", !valid_o, $sformatf("valid=%0b required 0", valid_o));
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("redir_addr", imem_read && imem_address == 32'h4000_0100 && !valid_o,
          $sformatf("read=%0b addr=%h valid=%0b required 1/40000100/0", imem_read, imem_address, valid_o));

    // Redirect in the same cycle as a response.
    drive(1'b0, 1'b1, 32'h4000_0200, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("redir_coinc", imem_read && imem_address == 32'h4000_0200 && !valid_o,
          $sformatf("read=%0b addr=%h valid=%0b required 1/40000200/0", imem_read, imem_address, valid_o));

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
          drive(1'b0, 1'b0, '0, 1'b0);
          @(negedge clk);
          got = imem_read;
        end
        @(posedge clk); #1;
        rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; imem_resp = 1'b0;
        @(posedge clk); #1;
        check("reset_mid_req", got && !imem_read && !valid_o,
              $sformatf("had_req=%0b read=%0b valid=%0b required 1/0/0", got, imem_read, valid_o));
        rst = 1'b1;
      end
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
            RESET_PC + (32'($urandom_range(0, 255)) << 2), ($urandom_range(0, 9) < 6));
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("deliveries", delivered >= 300, $sformatf("delivered=%0d required >=300", delivered));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
